// File: rtl/sub_irq_ctrl_pkg.sv
// Shared constants for the sub-CPU interrupt controller.
//   REG_IRQ_MASK : sub register address of the interrupt mask register
//   IRQ_*        : interrupt level assigned to each ASIC request source
//   IACK_FC      : fx68k function code that marks an interrupt-acknowledge cycle
package sub_irq_ctrl_pkg;

   localparam logic [8:0] REG_IRQ_MASK = 9'h032;

   localparam logic [2:0] IRQ_GFX   = 3'd1;
   localparam logic [2:0] IRQ_INT2  = 3'd2;
   localparam logic [2:0] IRQ_TIMER = 3'd3;
   localparam logic [2:0] IRQ_CDD   = 3'd4;
   localparam logic [2:0] IRQ_CDC   = 3'd5;
   localparam logic [2:0] IRQ_SCD   = 3'd6;

   localparam logic [2:0] IACK_FC   = 3'b111;

endpackage

// File: rtl/sub_irq_ctrl_if.sv
// Register-bus and fx68k interrupt-handshake signals of the sub-CPU interrupt controller.
//   sub_data / reg_addr / regs_we_lo_sub : low-byte register write port
//   reg_8032_do                          : mask register readback
//   cpu_fc / cpu_as / cpu_addr           : fx68k bus cycle qualifiers (IACK detection)
//   ipl / vpa                            : active-low interrupt level and autovector request
// master = CPU/bus side, slave = interrupt controller.
interface sub_irq_ctrl_if;

   logic [7:0]  sub_data;
   logic [14:0] reg_addr;
   logic        regs_we_lo_sub;
   logic [15:0] reg_8032_do;
   logic [2:0]  cpu_fc;
   logic        cpu_as;
   logic [2:0]  cpu_addr;
   logic [2:0]  ipl;
   logic        vpa;

   modport master (
      output sub_data, reg_addr, regs_we_lo_sub, cpu_fc, cpu_as, cpu_addr,
      input  reg_8032_do, ipl, vpa
   );

   modport slave (
      input  sub_data, reg_addr, regs_we_lo_sub, cpu_fc, cpu_as, cpu_addr,
      output reg_8032_do, ipl, vpa
   );

endinterface

// File: rtl/sub_irq_ctrl_prio_enc.sv
// Combinational 6-to-3 priority encoder for pending interrupt levels.
//   pend : pending flags, bit n-1 = level n
//   lvl  : highest pending level (6 wins), 0 when nothing is pending
module irq_prio_enc
   import sub_irq_ctrl_pkg::*;
(
   input  logic [5:0] pend,
   output logic [2:0] lvl
);

   // Highest set bit selects the level.
   always_comb begin
      lvl = 3'd0;
      casez (pend)
         6'b1?????: lvl = IRQ_SCD;
         6'b01????: lvl = IRQ_CDC;
         6'b001???: lvl = IRQ_CDD;
         6'b0001??: lvl = IRQ_TIMER;
         6'b00001?: lvl = IRQ_INT2;
         6'b000001: lvl = IRQ_GFX;
         default:   lvl = 3'd0;
      endcase
   end

endmodule

// File: rtl/sub_irq_ctrl.sv
// Sub-CPU interrupt controller and IACK autovector responder.
// Latches level 1..6 requests through the mask register, drives the prioritised
// level on the fx68k IPL pins and answers IACK cycles with VPA.
//   clk_asic, rst : clock, asynchronous active-high reset
//   sub_sync      : sub-CPU clock enable, every state change waits for it
//   irq_src       : request pulses, bit n-1 = level n
//   bus           : register write port, mask readback, fx68k IACK handshake
//   pend_do       : pending flags
//   iack_lvl      : level carried by the last acknowledge
module sub_irq_ctrl
   import sub_irq_ctrl_pkg::*;
#(
   parameter logic [7:0] MASK_RST = 8'h00,
   parameter logic [2:0] IACK_FC  = sub_irq_ctrl_pkg::IACK_FC
) (
   input  logic                clk_asic,
   input  logic                rst,
   input  logic                sub_sync,
   input  logic [5:0]          irq_src,
   sub_irq_ctrl_if.slave       bus,
   output logic [5:0]          pend_do,
   output logic [2:0]          iack_lvl
);

   logic [5:0] mask_r;
   logic [5:0] pend_r;
   logic       iack_q_r;
   logic [2:0] ipl_r;
   logic       vpa_r;
   logic [2:0] iack_lvl_r;

   logic       mask_we_s;
   logic [5:0] mask_next_s;
   logic       iack_s;
   logic       iack_edge_s;
   logic [5:0] clr_s;
   logic [5:0] pend_next_s;
   logic [2:0] l_hi_s;

   assign mask_we_s   = bus.regs_we_lo_sub & (bus.reg_addr == {6'b000000, REG_IRQ_MASK});
   assign iack_s      = (bus.cpu_fc == IACK_FC) & ~bus.cpu_as;
   assign iack_edge_s = iack_s & ~iack_q_r;

   // Mask in effect after this tick's write; set and mask-clear both use it.
   always_comb begin
      mask_next_s = mask_r;
      if (mask_we_s) begin
         mask_next_s = bus.sub_data[6:1];
      end else begin
         mask_next_s = mask_r;
      end
   end

   // One-hot clear for the acknowledged level; levels 0 and 7 clear nothing.
   always_comb begin
      clr_s = 6'b000000;
      if (iack_edge_s) begin
         case (bus.cpu_addr)
            3'd1:    clr_s = 6'b000001;
            3'd2:    clr_s = 6'b000010;
            3'd3:    clr_s = 6'b000100;
            3'd4:    clr_s = 6'b001000;
            3'd5:    clr_s = 6'b010000;
            3'd6:    clr_s = 6'b100000;
            default: clr_s = 6'b000000;
         endcase
      end else begin
         clr_s = 6'b000000;
      end
   end

   // Set overrides the IACK clear, the final mask AND overrides everything.
   always_comb begin
      pend_next_s = ((pend_r & ~clr_s) | (irq_src & mask_next_s)) & mask_next_s;
   end

   irq_prio_enc u_prio (
      .pend (pend_r),
      .lvl  (l_hi_s)
   );

   // Mask, pending flags and IACK edge history.
   always_ff @(posedge clk_asic or posedge rst) begin
      if (rst) begin
         mask_r   <= MASK_RST[6:1];
         pend_r   <= 6'b000000;
         iack_q_r <= 1'b0;
      end else if (sub_sync) begin
         mask_r   <= mask_next_s;
         pend_r   <= pend_next_s;
         iack_q_r <= iack_s;
      end
   end

   // CPU-facing outputs: IPL lags pend by one tick, VPA holds until AS rises.
   always_ff @(posedge clk_asic or posedge rst) begin
      if (rst) begin
         ipl_r      <= 3'b111;
         vpa_r      <= 1'b1;
         iack_lvl_r <= 3'd0;
      end else if (sub_sync) begin
         ipl_r <= ~l_hi_s;
         if (iack_edge_s) begin
            vpa_r      <= 1'b0;
            iack_lvl_r <= bus.cpu_addr;
         end else if (bus.cpu_as) begin
            vpa_r <= 1'b1;
         end
      end
   end

   assign bus.ipl         = ipl_r;
   assign bus.vpa         = vpa_r;
   assign bus.reg_8032_do = {9'b000000000, mask_r, 1'b0};
   assign pend_do         = pend_r;
   assign iack_lvl        = iack_lvl_r;

endmodule

// File: tb/tb_sub_irq_ctrl.sv
// Scoreboard bench for sub_irq_ctrl: expectations are queued as stimulus is
// driven and checked 1 time unit after the clock edge that should produce them.
module tb_sub_irq_ctrl;

   localparam logic [7:0] MASK_RST_TB = 8'h85;   // bits 7 and 0 must be dropped

   localparam int SEL_PEND = 0;
   localparam int SEL_IPL  = 1;
   localparam int SEL_VPA  = 2;
   localparam int SEL_LVL  = 3;
   localparam int SEL_REG  = 4;

   typedef struct {
      string       tag;
      int          sel;
      logic [15:0] exp;
   } exp_t;

   logic       clk_asic;
   logic       rst;
   logic       sub_sync;
   logic [5:0] irq_src;
   logic [5:0] pend_do;
   logic [2:0] iack_lvl;

   sub_irq_ctrl_if bus ();

   sub_irq_ctrl #(.MASK_RST(MASK_RST_TB)) dut (
      .clk_asic (clk_asic),
      .rst      (rst),
      .sub_sync (sub_sync),
      .irq_src  (irq_src),
      .bus      (bus.slave),
      .pend_do  (pend_do),
      .iack_lvl (iack_lvl)
   );

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk_asic = 1'b0;
   always #5 clk_asic = ~clk_asic;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] observe(input int sel);
      case (sel)
         SEL_PEND: return {10'd0, pend_do};
         SEL_IPL:  return {13'd0, bus.ipl};
         SEL_VPA:  return {15'd0, bus.vpa};
         SEL_LVL:  return {13'd0, iack_lvl};
         SEL_REG:  return bus.reg_8032_do;
         default:  return 16'hxxxx;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [15:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_asic);
      #1;
      drain();
   endtask

   task automatic set_iack(input logic [2:0] lvl);
      bus.cpu_fc   = 3'b111;
      bus.cpu_addr = lvl;
      bus.cpu_as   = 1'b0;
   endtask

   task automatic end_bus();
      bus.cpu_fc   = 3'b000;
      bus.cpu_addr = 3'd0;
      bus.cpu_as   = 1'b1;
   endtask

   initial begin
      rst                = 1'b1;
      sub_sync           = 1'b1;
      irq_src            = 6'b000000;
      bus.sub_data       = 8'h00;
      bus.reg_addr       = 15'h0000;
      bus.regs_we_lo_sub = 1'b0;
      end_bus();
      repeat (2) @(posedge clk_asic);
      #1;
      rst = 1'b0;
      push("rst_pend", SEL_PEND, 16'h0000);
      push("rst_ipl",  SEL_IPL,  16'h0007);
      push("rst_vpa",  SEL_VPA,  16'h0001);
      push("rst_lvl",  SEL_LVL,  16'h0000);
      push("rst_mask", SEL_REG,  16'h0004);
      drain();

      // Mask level 3 only, then request level 3 and a masked level 5.
      bus.reg_addr = 15'h0032; bus.sub_data = 8'h08; bus.regs_we_lo_sub = 1'b1;
      push("m08_reg", SEL_REG, 16'h0008);
      tick();
      bus.regs_we_lo_sub = 1'b0;
      irq_src = 6'b000100;
      push("l3_pend", SEL_PEND, 16'h0004);
      push("l3_ipl_lag", SEL_IPL, 16'h0007);
      tick();
      irq_src = 6'b000000;
      push("l3_ipl", SEL_IPL, 16'h0004);
      tick();
      irq_src = 6'b010000;
      push("l5_masked", SEL_PEND, 16'h0004);
      tick();
      irq_src = 6'b000000;

      // Open all levels, request 3 and 5, acknowledge 5.
      bus.sub_data = 8'h7E; bus.regs_we_lo_sub = 1'b1;
      push("m7e_reg", SEL_REG, 16'h007E);
      tick();
      bus.regs_we_lo_sub = 1'b0;
      irq_src = 6'b010100;
      push("l35_pend", SEL_PEND, 16'h0014);
      tick();
      irq_src = 6'b000000;
      push("l35_ipl", SEL_IPL, 16'h0002);
      tick();
      set_iack(3'd5);
      push("ack5_vpa", SEL_VPA, 16'h0000);
      push("ack5_lvl", SEL_LVL, 16'h0005);
      push("ack5_pend", SEL_PEND, 16'h0004);
      push("ack5_ipl_lag", SEL_IPL, 16'h0002);
      tick();
      push("ack5_ipl", SEL_IPL, 16'h0004);
      push("ack5_vpa_hold", SEL_VPA, 16'h0000);
      tick();
      end_bus();
      push("ack5_vpa_rel", SEL_VPA, 16'h0001);
      tick();

      // New level-3 request in the same tick as its own acknowledge stays pending.
      set_iack(3'd3);
      irq_src = 6'b000100;
      push("ack3set_pend", SEL_PEND, 16'h0004);
      push("ack3set_vpa", SEL_VPA, 16'h0000);
      push("ack3set_lvl", SEL_LVL, 16'h0003);
      tick();
      irq_src = 6'b000000;
      push("ack3set_ipl", SEL_IPL, 16'h0004);
      tick();
      end_bus();
      push("ack3set_rel", SEL_VPA, 16'h0001);
      tick();
      set_iack(3'd3);
      push("ack3_clr", SEL_PEND, 16'h0000);
      tick();
      end_bus();
      push("ack3_ipl", SEL_IPL, 16'h0007);
      push("ack3_rel", SEL_VPA, 16'h0001);
      tick();

      // Level 4 pending, mask cleared with a same-tick level-4 request.
      irq_src = 6'b001000;
      push("l4_pend", SEL_PEND, 16'h0008);
      tick();
      irq_src = 6'b000000;
      push("l4_ipl", SEL_IPL, 16'h0003);
      tick();
      bus.sub_data = 8'h00; bus.regs_we_lo_sub = 1'b1;
      irq_src = 6'b001000;
      push("m00_pend", SEL_PEND, 16'h0000);
      push("m00_reg", SEL_REG, 16'h0000);
      tick();
      bus.regs_we_lo_sub = 1'b0;
      irq_src = 6'b000000;
      push("m00_ipl", SEL_IPL, 16'h0007);
      tick();

      // Spurious acknowledge with nothing pending.
      set_iack(3'd7);
      push("sp7_vpa", SEL_VPA, 16'h0000);
      push("sp7_lvl", SEL_LVL, 16'h0007);
      push("sp7_pend", SEL_PEND, 16'h0000);
      tick();
      end_bus();
      push("sp7_rel", SEL_VPA, 16'h0001);
      tick();

      // No state change without sub_sync.
      sub_sync = 1'b0;
      bus.sub_data = 8'h7E; bus.regs_we_lo_sub = 1'b1;
      irq_src = 6'b111111;
      push("nosync_reg", SEL_REG, 16'h0000);
      push("nosync_pend", SEL_PEND, 16'h0000);
      tick();
      sub_sync = 1'b1;
      irq_src = 6'b000010;
      push("l2_reg", SEL_REG, 16'h007E);
      push("l2_pend", SEL_PEND, 16'h0002);
      tick();
      bus.regs_we_lo_sub = 1'b0;
      irq_src = 6'b000000;
      push("l2_ipl", SEL_IPL, 16'h0005);
      tick();

      // Asynchronous reset in the middle of an acknowledge.
      set_iack(3'd2);
      push("ack2_vpa", SEL_VPA, 16'h0000);
      tick();
      #2;
      rst = 1'b1;
      #1;
      push("arst_vpa", SEL_VPA, 16'h0001);
      push("arst_ipl", SEL_IPL, 16'h0007);
      push("arst_reg", SEL_REG, {8'h00, MASK_RST_TB & 8'h7E});
      push("arst_pend", SEL_PEND, 16'h0000);
      push("arst_lvl", SEL_LVL, 16'h0000);
      drain();
      end_bus();
      tick();
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sub_irq_ctrl.md
Name: sub_irq_ctrl

Overview:
Sub-CPU interrupt controller and interrupt-acknowledge responder for the MCD mapper. It latches level 1–6 interrupt requests from the ASIC blocks (graphics, main-CPU INT2, timer 8030, CDD, CDC, subcode) and gates them through the mask register at 0x032. It drives the prioritised level onto the fx68k IPL pins and answers the CPU's IACK cycle with an autovector (VPA), clearing the acknowledged request.

Parameters:
- MASK_RST, 8'h00, reset value of mask bits [6:1] (bit 0 and bit 7 are ignored).
- IACK_FC, 3'b111, function-code value that identifies an interrupt-acknowledge cycle.

Ports:
- clk_asic  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sub_sync  in  1  sub-CPU clock-enable; all state advances only when it is 1
- irq_src  in  6  request pulses; bit n-1 = level n; each is sampled per sub_sync tick
- sub_data  in  8  register write data (low byte)
- reg_addr  in  15  sub register address
- regs_we_lo_sub  in  1  low-byte register write strobe
- cpu_fc  in  3  fx68k function code
- cpu_as  in  1  fx68k address strobe, active-low
- cpu_addr  in  3  fx68k address [3:1]; carries the IACK level
- ipl  out  3  to fx68k IPL2..0, active-low
- vpa  out  1  to fx68k VPAn, active-low autovector request
- reg_8032_do  out  16  readback: [6:1] mask, other bits 0
- pend_do  out  6  pending flags, for debug and readback
- iack_lvl  out  3  level of the last completed acknowledge

Behaviour:
- Reset (async): mask = MASK_RST[6:1]; pending = 0; ipl = 3'b111; vpa = 1; iack_lvl = 0; internal IACK-edge register = 0.
- All updates below happen on clk_asic edges where sub_sync = 1.
- Mask write: regs_we_lo_sub & reg_addr == 9'h032 loads mask <= sub_data[6:1].
  - Pending bits whose new mask bit is 0 are cleared in the same tick.
- Set: pend[n] is set when irq_src[n] = 1 and the mask bit in effect after this tick's write is 1.
- Clear: a completed IACK for level L clears pend[L].
- Priority of simultaneous events on one bit:
  - mask-clear beats set;
  - set beats IACK-clear, so a new event during its own acknowledge stays pending.
- Level select: L_hi = highest set pend index (6 > 5 > … > 1), or 0 if none.
- ipl <= ~L_hi, registered, so it appears one tick after pend changes. ipl = 3'b111 when nothing is pending.
- IACK detect: iack = (cpu_fc == IACK_FC) & !cpu_as. It is registered as iack_q; the rising edge is iack & !iack_q.
- On the rising edge:
  - vpa <= 0;
  - iack_lvl <= cpu_addr;
  - pend[cpu_addr] is cleared, subject to the set priority above.
- vpa returns to 1 on the first tick where cpu_as = 1. vpa = 0 is never held outside an IACK cycle.
- Spurious IACK (cpu_addr = 0, 7, or a level that is not pending): vpa is still asserted (autovector), iack_lvl is updated, and no pend bit changes.
- A new IACK edge while vpa = 0 cannot occur, because AS must rise first. No re-trigger within one cycle.
- A reset asserted during IACK forces vpa = 1 immediately; the CPU is reset alongside.
- The irq_src pulse contract: a level held high for many ticks re-sets the bit every tick, so holding it acts as level-sensitive.

Decomposition:
- Shared mcd package holds:
  - constant REG_IRQ_MASK = 9'h032;
  - IRQ level constants IRQ_GFX = 1, IRQ_INT2 = 2, IRQ_TIMER = 3, IRQ_CDD = 4, IRQ_CDC = 5, IRQ_SCD = 6;
  - IACK_FC.
- One sub-module, irq_prio_enc: combinational 6-to-3 priority encoder producing L_hi.
- Everything else stays in sub_irq_ctrl.

Test Plan:
- Reset, then write 0x032 = 8'h08 (mask level 3 only), pulse irq_src[2] → pend_do = 6'b000100, ipl = 3'b100 one tick later. Pulse irq_src[4] → no change.
- Mask 8'h7E; pulse levels 3 and 5 together → ipl = ~5 = 3'b010. IACK with cpu_addr = 5 → vpa = 0 one tick after the AS-low edge and ipl becomes 3'b100. AS rising → vpa = 1.
- Pulse level 3 in the same tick as the level-3 IACK edge → pend[3] stays 1 and ipl remains 3'b100.
- Level 4 pending, then write mask = 0 → pend_do = 0 and ipl = 3'b111 next tick. A same-tick irq_src[3] pulse → still cleared.
- Spurious IACK with cpu_addr = 7 and nothing pending → vpa pulses low, iack_lvl = 7, pend_do unchanged at 0.
- Assert rst asynchronously mid-IACK with vpa = 0 → vpa = 1, ipl = 3'b111, reg_8032_do = MASK_RST & 16'h007E without waiting for a clock edge.
